// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped cache: controller state encoding,
// default field widths and the derived word-address layout. The data-RAM
// wrapper imports the same constants so both sides agree on {tag, index, offset}.
// -----------------------------------------------------------------------------
package cache_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REFILL = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Default geometry
  localparam int unsigned TAG_ADDR_WIDTH_DEF = 8;
  localparam int unsigned TAG_LENGTH_DEF     = 9;
  localparam int unsigned OFFSET_WIDTH_DEF   = 2;
  localparam int unsigned DATA_WIDTH_DEF     = 32;
  localparam int unsigned CNT_WIDTH_DEF      = 16;

  // Word address = {tag, index, offset}
  function automatic int unsigned addr_width(input int unsigned tag_len,
                                             input int unsigned idx_w,
                                             input int unsigned off_w);
    return tag_len + idx_w + off_w;
  endfunction

  localparam int unsigned ADDR_WIDTH = TAG_LENGTH_DEF + TAG_ADDR_WIDTH_DEF + OFFSET_WIDTH_DEF;
  localparam int unsigned OFFSET_LSB = 0;
  localparam int unsigned INDEX_LSB  = OFFSET_WIDTH_DEF;
  localparam int unsigned TAG_LSB    = OFFSET_WIDTH_DEF + TAG_ADDR_WIDTH_DEF;

endpackage

// File: rtl/cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// cache_tag_ctrl
// Direct-mapped cache lookup/refill controller. Owns the per-line valid bits,
// drives the external tag RAM (read registered on the falling clock edge),
// compares tags, fetches missing lines word by word from memory into the data
// RAM and finally writes the new tag.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   CpuReq/CpuAddr      load request (held until CpuAck) and word address
//   Flush               invalidate every line (only honoured in IDLE)
//   CpuAck              one-cycle pulse: addressed line is resident
//   Busy                controller is not IDLE
//   TagAddr/TagIn/TagWrite/TagOut   tag RAM port
//   MemReq/MemAddr/MemValid/MemData line fetch interface
//   DataRamAddr/DataRamWrData/DataRamWrite  data RAM write port
//   HitCount/MissCount  saturating statistics counters
// -----------------------------------------------------------------------------
module cache_tag_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned TAG_ADDR_WIDTH = TAG_ADDR_WIDTH_DEF,
  parameter int unsigned TAG_LENGTH     = TAG_LENGTH_DEF,
  parameter int unsigned OFFSET_WIDTH   = OFFSET_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF,
  localparam int unsigned AW            = addr_width(TAG_LENGTH, TAG_ADDR_WIDTH, OFFSET_WIDTH)
) (
  input  logic                                 Clk,
  input  logic                                 Reset_n,
  input  logic                                 CpuReq,
  input  logic [AW-1:0]                        CpuAddr,
  input  logic                                 Flush,
  output logic                                 CpuAck,
  output logic                                 Busy,
  output logic [TAG_ADDR_WIDTH-1:0]            TagAddr,
  output logic [TAG_LENGTH-1:0]                TagIn,
  output logic                                 TagWrite,
  input  logic [TAG_LENGTH-1:0]                TagOut,
  output logic                                 MemReq,
  output logic [AW-1:0]                        MemAddr,
  input  logic                                 MemValid,
  input  logic [DATA_WIDTH-1:0]                MemData,
  output logic [TAG_ADDR_WIDTH+OFFSET_WIDTH-1:0] DataRamAddr,
  output logic [DATA_WIDTH-1:0]                DataRamWrData,
  output logic                                 DataRamWrite,
  output logic [CNT_WIDTH-1:0]                 HitCount,
  output logic [CNT_WIDTH-1:0]                 MissCount
);

  localparam int unsigned DEPTH  = 2 ** TAG_ADDR_WIDTH;
  localparam int unsigned LINE_W = TAG_LENGTH + TAG_ADDR_WIDTH;

  // Saturating increment: holds at all-ones instead of wrapping
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  state_e                    state_q, state_d;
  logic [LINE_W-1:0]         line_q, line_d;     // latched {tag, index}; offset is not needed
  logic [OFFSET_WIDTH-1:0]   count_q, count_d;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [CNT_WIDTH-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]      miss_cnt_q, miss_cnt_d;

  logic [TAG_LENGTH-1:0]     lat_tag_s;
  logic [TAG_ADDR_WIDTH-1:0] lat_idx_s;
  logic [TAG_ADDR_WIDTH-1:0] cpu_idx_s;
  logic                      hit_s;
  logic                      last_word_s;
  logic                      unused_s;

  assign lat_tag_s   = line_q[LINE_W-1 -: TAG_LENGTH];
  assign lat_idx_s   = line_q[TAG_ADDR_WIDTH-1:0];
  assign cpu_idx_s   = CpuAddr[OFFSET_WIDTH +: TAG_ADDR_WIDTH];
  // TagOut reflects TagAddr sampled on the falling edge inside LOOKUP
  assign hit_s       = valid_q[lat_idx_s] && (TagOut == lat_tag_s);
  assign last_word_s = (count_q == {OFFSET_WIDTH{1'b1}});
  // Word offset of the request is irrelevant to a whole-line fill
  assign unused_s    = ^CpuAddr[OFFSET_WIDTH-1:0];

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      line_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    count_d    = count_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Flush) begin
          valid_d = '0;
        end else if (CpuReq) begin
          line_d  = CpuAddr[AW-1:OFFSET_WIDTH];
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = ST_DONE;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          count_d    = '0;
          state_d    = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (MemValid) begin
          count_d = count_q + OFFSET_WIDTH'(1);
          if (last_word_s) begin
            state_d = ST_UPDATE;
          end else begin
            state_d = ST_REFILL;
          end
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_UPDATE: begin
        valid_d[lat_idx_s] = 1'b1;
        state_d            = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the current state
  always_comb begin
    CpuAck       = 1'b0;
    Busy         = (state_q != ST_IDLE);
    TagAddr      = lat_idx_s;
    TagIn        = '0;
    TagWrite     = 1'b0;
    MemReq       = 1'b0;
    MemAddr      = '0;
    DataRamAddr  = {lat_idx_s, count_q};
    DataRamWrData = MemData;
    DataRamWrite = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Present the incoming index early so the tag read lands in LOOKUP
        TagAddr = cpu_idx_s;
      end
      ST_LOOKUP: begin
        TagAddr = lat_idx_s;
      end
      ST_REFILL: begin
        MemReq       = 1'b1;
        MemAddr      = {line_q, {OFFSET_WIDTH{1'b0}}};
        DataRamWrite = MemValid;
      end
      ST_UPDATE: begin
        TagWrite = 1'b1;
        TagIn    = lat_tag_s;
      end
      ST_DONE: begin
        CpuAck = 1'b1;
      end
      default: begin
        CpuAck = 1'b0;
      end
    endcase
  end

  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_tag_ctrl
// Directed bench for cache_tag_ctrl with a behavioural tag RAM (negedge read
// and write) and a scoreboard of expected data-RAM writes. The counters are
// built 2 bits wide so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_cache_tag_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        CpuReq;
  logic [18:0] CpuAddr;
  logic        Flush;
  logic        CpuAck;
  logic        Busy;
  logic [7:0]  TagAddr;
  logic [8:0]  TagIn;
  logic        TagWrite;
  logic [8:0]  TagOut;
  logic        MemReq;
  logic [18:0] MemAddr;
  logic        MemValid;
  logic [31:0] MemData;
  logic [9:0]  DataRamAddr;
  logic [31:0] DataRamWrData;
  logic        DataRamWrite;
  logic [1:0]  HitCount;
  logic [1:0]  MissCount;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [8:0] tag_mem [0:255];

  always #5 Clk = ~Clk;

  cache_tag_ctrl #(.CNT_WIDTH(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .CpuReq(CpuReq), .CpuAddr(CpuAddr), .Flush(Flush),
    .CpuAck(CpuAck), .Busy(Busy), .TagAddr(TagAddr), .TagIn(TagIn), .TagWrite(TagWrite),
    .TagOut(TagOut), .MemReq(MemReq), .MemAddr(MemAddr), .MemValid(MemValid),
    .MemData(MemData), .DataRamAddr(DataRamAddr), .DataRamWrData(DataRamWrData),
    .DataRamWrite(DataRamWrite), .HitCount(HitCount), .MissCount(MissCount)
  );

  // Tag RAM model: read registered on the falling edge, read-before-write
  always @(negedge Clk) begin
    if (TagWrite) tag_mem[TagAddr] <= TagIn;
    TagOut <= tag_mem[TagAddr];
  end

  // Data RAM write monitor against the scoreboard
  always @(negedge Clk) begin
    if (Reset_n && DataRamWrite) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL dram_unexpected observed addr=%0h data=%0h expected no write", DataRamAddr, DataRamWrData);
      end else begin
        e = exp_q.pop_front();
        assert ({DataRamAddr, DataRamWrData} === e) else begin
          failures++;
          $error("FAIL dram_write observed addr=%0h data=%0h expected addr=%0h data=%0h",
                 DataRamAddr, DataRamWrData, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // One complete CPU access; on a miss, words are supplied with an optional idle gap
  task automatic do_access(input logic [18:0] a, input bit hit, input logic [31:0] dbase,
                           input int gap, input int exp_hits, input int exp_miss);
    logic [8:0] tag;
    logic [7:0] idx;
    logic [1:0] w2;
    tag = a[18:10];
    idx = a[9:2];
    CpuReq  = 1'b1;
    CpuAddr = a;
    #1;
    chk("idle_busy", Busy, 0);
    chk("idle_tagaddr", TagAddr, idx);
    cyc();
    // LOOKUP: a changed CpuAddr must not disturb the latched index
    CpuAddr = a ^ 19'h7FFFF;
    #1;
    chk("lookup_tagaddr", TagAddr, idx);
    chk("lookup_busy", Busy, 1);
    chk("lookup_ack", CpuAck, 0);
    chk("lookup_memreq", MemReq, 0);
    cyc();
    if (!hit) begin
      chk("refill_memreq", MemReq, 1);
      chk("refill_memaddr", MemAddr, {tag, idx, 2'b00});
      chk("refill_ack", CpuAck, 0);
      for (int w = 0; w < 4; w++) begin
        if (w == gap) begin
          MemValid = 1'b0;
          cyc();
          chk("gap_memreq", MemReq, 1);
        end
        w2 = 2'(w);
        MemValid = 1'b1;
        MemData  = dbase + 32'(w);
        exp_q.push_back({idx, w2, dbase + 32'(w)});
        cyc();
      end
      MemValid = 1'b0;
      MemData  = 32'h0;
      #1;
      chk("update_tagwrite", TagWrite, 1);
      chk("update_tagin", TagIn, tag);
      chk("update_tagaddr", TagAddr, idx);
      chk("update_memreq", MemReq, 0);
      chk("update_ack", CpuAck, 0);
      cyc();
    end
    // DONE: hit lands here two cycles after the request was sampled
    chk("done_ack", CpuAck, 1);
    chk("done_memreq", MemReq, 0);
    chk("done_tagwrite", TagWrite, 0);
    chk("hit_count", HitCount, exp_hits);
    chk("miss_count", MissCount, exp_miss);
    CpuReq = 1'b0;
    cyc();
    chk("after_ack", CpuAck, 0);
    chk("after_busy", Busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tag_mem[i] = 9'h0;
    Reset_n  = 1'b0;
    CpuReq   = 1'b0;
    CpuAddr  = 19'h0;
    Flush    = 1'b0;
    MemValid = 1'b0;
    MemData  = 32'h0;
    cyc();
    cyc();
    // Reset state
    chk("rst_busy", Busy, 0);
    chk("rst_ack", CpuAck, 0);
    chk("rst_tagaddr", TagAddr, 0);
    chk("rst_tagin", TagIn, 0);
    chk("rst_tagwrite", TagWrite, 0);
    chk("rst_memreq", MemReq, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_dramaddr", DataRamAddr, 0);
    chk("rst_dramwrite", DataRamWrite, 0);
    chk("rst_hits", HitCount, 0);
    chk("rst_miss", MissCount, 0);
    Reset_n = 1'b1;
    cyc();

    // Cold miss with a one-cycle gap in the word stream, then a hit
    do_access(19'h00404, 1'b0, 32'hA0, 1, 0, 1);
    do_access(19'h00406, 1'b1, 32'h0, -1, 1, 1);
    // Conflict pair, then miss counter saturates at 3
    do_access(19'h00804, 1'b0, 32'hB0, -1, 1, 2);
    do_access(19'h00404, 1'b0, 32'hC0, -1, 1, 3);
    do_access(19'h00804, 1'b0, 32'hD0, 2, 1, 3);
    do_access(19'h00805, 1'b1, 32'h0, -1, 2, 3);

    // Flush wins over a simultaneous request
    Flush  = 1'b1;
    CpuReq = 1'b1;
    CpuAddr = 19'h00804;
    cyc();
    chk("flush_stays_idle", Busy, 0);
    Flush  = 1'b0;
    CpuReq = 1'b0;
    cyc();
    chk("flush_tagout_stale", TagOut, 9'h002);
    do_access(19'h00804, 1'b0, 32'hE0, -1, 2, 3);

    // Stray memory data while idle is ignored
    MemValid = 1'b1;
    MemData  = 32'hDEAD;
    #1;
    chk("idle_memvalid_nowrite", DataRamWrite, 0);
    cyc();
    cyc();
    MemValid = 1'b0;
    MemData  = 32'h0;

    // Asynchronous reset in the middle of a refill
    CpuReq  = 1'b1;
    CpuAddr = 19'h00404;
    cyc();
    cyc();
    chk("pre_rst_memreq", MemReq, 1);
    for (int w = 0; w < 2; w++) begin
      MemValid = 1'b1;
      MemData  = 32'hF0 + 32'(w);
      exp_q.push_back({8'h01, 2'(w), 32'hF0 + 32'(w)});
      cyc();
    end
    MemValid = 1'b0;
    MemData  = 32'h0;
    CpuReq   = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_memreq", MemReq, 0);
    chk("arst_busy", Busy, 0);
    chk("arst_hits", HitCount, 0);
    chk("arst_miss", MissCount, 0);
    CpuAddr = 19'h0;
    #1;
    chk("arst_dramaddr", DataRamAddr, 0);
    cyc();
    Reset_n = 1'b1;
    cyc();
    do_access(19'h00404, 1'b0, 32'hA0, -1, 0, 1);

    // Hit counter saturates at 3
    do_access(19'h00404, 1'b1, 32'h0, -1, 1, 1);
    do_access(19'h00405, 1'b1, 32'h0, -1, 2, 1);
    do_access(19'h00406, 1'b1, 32'h0, -1, 3, 1);
    do_access(19'h00407, 1'b1, 32'h0, -1, 3, 1);
    do_access(19'h00404, 1'b1, 32'h0, -1, 3, 1);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
